// File: rtl/parallel_tx_handshake_ctrl.sv
// Source side of the inter-FPGA parallel link: valid/ready intake, registered
// bus drive, 4-phase req/ack sequencing against a synchronized remote ack.
module parallel_tx_handshake_ctrl #(
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic              clk_src,
    input  logic              rst_src_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    input  logic              tx_ack_async,
    input  logic              clr_err,
    output logic              busy,
    output logic              err_timeout,
    output logic [15:0]       xfer_cnt
);

    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_LAST = (TIMEOUT > 0) ? PW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {IDLE, SETUP, WAIT_HI, WAIT_LO, ERR} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ack_ff;
    logic                   ack_sync;
    logic [SW-1:0]          setup_cnt;
    logic [PW-1:0]          phase_cnt;
    logic                   phase_to;
    logic                   accept;
    logic                   done;

    // Remote ack is asynchronous; only the last flop of this chain is used.
    always_ff @(posedge clk_src or negedge rst_src_n) begin
        if (!rst_src_n) ack_ff <= '0;
        else            ack_ff <= {ack_ff[SYNC_STAGES-2:0], tx_ack_async};
    end
    assign ack_sync = ack_ff[SYNC_STAGES-1];

    // Fires on the last permitted cycle of a wait phase; exit conditions take priority.
    assign phase_to = (TIMEOUT != 0) && (phase_cnt == PHASE_LAST);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    state_d = SETUP;
                    accept  = 1'b1;
                end
            end
            SETUP: begin
                if (setup_cnt == '0) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (ack_sync)      state_d = WAIT_LO;
                else if (phase_to) state_d = ERR;
            end
            WAIT_LO: begin
                if (!ack_sync) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end else if (phase_to) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (clr_err && !ack_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_src or negedge rst_src_n) begin
        if (!rst_src_n) begin
            state_q     <= IDLE;
            s_ready     <= 1'b0;
            tx_req      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_ready     <= (state_d == IDLE);
            tx_req      <= (state_d == WAIT_HI);
            err_timeout <= (state_d == ERR);
        end
    end

    always_ff @(posedge clk_src or negedge rst_src_n) begin
        if (!rst_src_n) begin
            setup_cnt <= '0;
            phase_cnt <= '0;
            tx_data   <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (accept)
                setup_cnt <= SETUP_LOAD;
            else if (state_q == SETUP && setup_cnt != '0)
                setup_cnt <= setup_cnt - 1'b1;

            // Cleared on every state change, so each wait phase starts from zero.
            if (state_d != state_q)
                phase_cnt <= '0;
            else if (state_q == WAIT_HI || state_q == WAIT_LO)
                phase_cnt <= phase_cnt + 1'b1;

            if (accept) tx_data  <= s_data;
            if (done)   xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_parallel_tx_handshake_ctrl.sv
// Directed bench for parallel_tx_handshake_ctrl with a simple remote-ack model.
module tb_parallel_tx_handshake_ctrl;

    localparam int DATA_W  = 8;
    localparam int SYNC    = 2;
    localparam int SETUP   = 2;
    localparam int TMO     = 16;

    logic              clk_src;
    logic              rst_src_n;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_req;
    logic              tx_ack_async;
    logic              clr_err;
    logic              busy;
    logic              err_timeout;
    logic [15:0]       xfer_cnt;

    int  total  = 0;
    int  passed = 0;
    bit  remote_en = 0;
    int  rdly = 0;

    parallel_tx_handshake_ctrl #(
        .DATA_W(DATA_W), .SYNC_STAGES(SYNC), .SETUP_CYCLES(SETUP), .TIMEOUT(TMO)
    ) dut (
        .clk_src(clk_src), .rst_src_n(rst_src_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .tx_data(tx_data), .tx_req(tx_req), .tx_ack_async(tx_ack_async),
        .clr_err(clr_err), .busy(busy), .err_timeout(err_timeout), .xfer_cnt(xfer_cnt)
    );

    initial begin
        clk_src = 0;
        forever #5 clk_src = ~clk_src;
    end

    // Remote receiver: follows tx_req with a 3-cycle delay in both directions.
    initial begin
        tx_ack_async = 0;
        forever begin
            @(negedge clk_src);
            if (remote_en && tx_req !== tx_ack_async) begin
                rdly++;
                if (rdly >= 3) begin
                    tx_ack_async = tx_req;
                    rdly = 0;
                end
            end else begin
                rdly = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_src);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d);
        @(negedge clk_src);
        s_data  = d;
        s_valid = 1;
        tick();
        s_valid = 0;
    endtask

    task automatic wait_ready(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (s_ready === 1'b1) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst_src_n = 0; s_valid = 0; s_data = '0; clr_err = 0;
        #12;
        total++; if ({s_ready, tx_req, busy, err_timeout} !== 4'b0000) $display("FAIL reset_ctrl got=%b exp=0000", {s_ready, tx_req, busy, err_timeout}); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", tx_data); else passed++;
        total++; if (xfer_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); else passed++;
        @(negedge clk_src); rst_src_n = 1;
        tick();
        total++; if (s_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", s_ready); else passed++;
    endtask

    task automatic test_single();
        bit ok;
        remote_en = 1;
        send_word(8'hA5);
        total++; if (tx_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", tx_data); else passed++;
        total++; if ({s_ready, busy, tx_req} !== 3'b010) $display("FAIL single_accept got=%b exp=010", {s_ready, busy, tx_req}); else passed++;
        tick();
        total++; if (tx_req !== 1'b0) $display("FAIL single_req_early got=%b exp=0", tx_req); else passed++;
        tick();
        total++; if (tx_req !== 1'b1) $display("FAIL single_req_rise got=%b exp=1", tx_req); else passed++;
        wait_ready(60, ok);
        total++; if (!ok) $display("FAIL single_done got=timeout exp=s_ready"); else passed++;
        total++; if ({xfer_cnt, busy, tx_req} !== {16'd1, 2'b00}) $display("FAIL single_end got=%0d/%b/%b exp=1/0/0", xfer_cnt, busy, tx_req); else passed++;
    endtask

    task automatic test_back_to_back();
        int n = 0, cyc = 0, ack_lo = 0;
        logic [15:0] base;
        logic rdy_before, prev_req;
        bit viol = 0, ok;
        base = xfer_cnt;
        prev_req = tx_req;
        remote_en = 1;
        @(negedge clk_src);
        s_data = 8'h01; s_valid = 1;
        rdy_before = s_ready;
        while (n < 4 && cyc < 400) begin
            tick(); cyc++;
            if (rdy_before) begin
                n++;
                total++; if (tx_data !== 8'(n)) $display("FAIL b2b_word%0d got=%h exp=%h", n, tx_data, 8'(n)); else passed++;
                s_data = 8'(n + 1);
                if (n == 4) s_valid = 0;
            end
            if (tx_req && !prev_req && ack_lo < SYNC) viol = 1;
            prev_req = tx_req;
            ack_lo = tx_ack_async ? 0 : ack_lo + 1;
            rdy_before = s_ready;
        end
        total++; if (n != 4) $display("FAIL b2b_words got=%0d exp=4", n); else passed++;
        wait_ready(60, ok);
        total++; if (viol || !ok) $display("FAIL b2b_req_order got=viol%0d_ok%0d exp=viol0_ok1", viol, ok); else passed++;
        total++; if (xfer_cnt - base !== 16'd4) $display("FAIL b2b_count got=%0d exp=4", xfer_cnt - base); else passed++;
    endtask

    task automatic test_timeout();
        logic [15:0] base;
        remote_en = 0; tx_ack_async = 0;
        base = xfer_cnt;
        send_word(8'h3C);
        tick(); tick();
        total++; if (tx_req !== 1'b1) $display("FAIL tmo_req got=%b exp=1", tx_req); else passed++;
        repeat (TMO - 1) tick();
        total++; if ({tx_req, err_timeout} !== 2'b10) $display("FAIL tmo_early got=%b exp=10", {tx_req, err_timeout}); else passed++;
        tick();
        total++; if ({tx_req, err_timeout, s_ready, busy} !== 4'b0101) $display("FAIL tmo_err got=%b exp=0101", {tx_req, err_timeout, s_ready, busy}); else passed++;
        total++; if (xfer_cnt !== base) $display("FAIL tmo_cnt got=%0d exp=%0d", xfer_cnt, base); else passed++;
        @(negedge clk_src); clr_err = 1;
        tick(); clr_err = 0;
        total++; if ({err_timeout, busy, s_ready} !== 3'b001) $display("FAIL tmo_clear got=%b exp=001", {err_timeout, busy, s_ready}); else passed++;
    endtask

    task automatic test_stuck_ack();
        bit hit = 0;
        remote_en = 0; tx_ack_async = 0;
        send_word(8'h5A);
        tick(); tick();
        @(negedge clk_src); tx_ack_async = 1;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick();
            if (err_timeout === 1'b1) hit = 1;
        end
        total++; if (!hit || tx_req !== 1'b0) $display("FAIL stuck_enter got=hit%0d_req%b exp=hit1_req0", hit, tx_req); else passed++;
        @(negedge clk_src); clr_err = 1;
        tick(); clr_err = 0;
        total++; if ({err_timeout, busy} !== 2'b11) $display("FAIL stuck_hold got=%b exp=11", {err_timeout, busy}); else passed++;
        @(negedge clk_src); tx_ack_async = 0;
        repeat (3) tick();
        total++; if ({err_timeout, busy} !== 2'b11) $display("FAIL stuck_noclr got=%b exp=11", {err_timeout, busy}); else passed++;
        @(negedge clk_src); clr_err = 1;
        tick(); clr_err = 0;
        total++; if ({err_timeout, busy, s_ready} !== 3'b001) $display("FAIL stuck_release got=%b exp=001", {err_timeout, busy, s_ready}); else passed++;
    endtask

    task automatic test_reset_mid();
        remote_en = 0; tx_ack_async = 0;
        send_word(8'h77);
        tick(); tick();
        total++; if (tx_req !== 1'b1) $display("FAIL rmid_req got=%b exp=1", tx_req); else passed++;
        #3 rst_src_n = 0;
        #1;
        total++; if ({tx_req, tx_data} !== {1'b0, 8'h00}) $display("FAIL rmid_async got=%b/%h exp=0/00", tx_req, tx_data); else passed++;
        total++; if ({xfer_cnt, s_ready, busy} !== {16'd0, 2'b00}) $display("FAIL rmid_state got=%0d/%b/%b exp=0/0/0", xfer_cnt, s_ready, busy); else passed++;
        @(negedge clk_src); rst_src_n = 1;
        tick();
        total++; if (s_ready !== 1'b1) $display("FAIL rmid_ready got=%b exp=1", s_ready); else passed++;
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge clk_src);
        force dut.xfer_cnt = 16'hFFFF;
        @(negedge clk_src);
        release dut.xfer_cnt;
        remote_en = 1;
        send_word(8'hC3);
        wait_ready(60, ok);
        total++; if (!ok || xfer_cnt !== 16'd0) $display("FAIL wrap got=%0d_ok%0d exp=0_ok1", xfer_cnt, ok); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_stuck_ack();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
